// File: rtl/gelato_compute_unit_if.sv
// Compute-task handshake between the scheduler (master) and the SIMD ALU (slave).
interface gelato_compute_task_if #(
  parameter int unsigned THREAD_NUM = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                             valid;
  logic [3:0]                       op;
  logic [THREAD_NUM*DATA_WIDTH-1:0] rs1;
  logic [THREAD_NUM*DATA_WIDTH-1:0] rs2;
  logic [THREAD_NUM*DATA_WIDTH-1:0] rd;
  logic                             done;

  modport master (output valid, op, rs1, rs2, input rd, done);
  modport slave  (input valid, op, rs1, rs2, output rd, done);
endinterface

// File: rtl/gelato_compute_unit.sv
// Per-warp SIMD ALU: latches a task, computes LANES threads per enabled cycle,
// and returns the full result vector with a level done handshake.
module gelato_compute_unit #(
  parameter int unsigned THREAD_NUM = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  gelato_compute_task_if.slave  compute_task,
  output logic                  op_err
);
  localparam int unsigned GROUPS = THREAD_NUM / LANES;
  localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned SHW    = $clog2(DATA_WIDTH);
  localparam int unsigned VW     = THREAD_NUM * DATA_WIDTH;
  localparam int unsigned GW     = LANES * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR   = 4'd3,
    OP_XOR  = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA  = 4'd7,
    OP_SLT  = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10
  } op_t;

  state_t          state;
  op_t             op_q;
  logic [VW-1:0]   rs1_q, rs2_q, rd_q;
  logic [CW-1:0]   cnt;
  logic            done_q;
  logic [GW-1:0]   grp_res;
  int unsigned     grp_base;

  function automatic logic [DATA_WIDTH-1:0] alu(
    input op_t                   op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] r;
    logic [SHW-1:0]        sh;
    sh = b[SHW-1:0];
    unique case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      OP_MUL:  r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign grp_base = LANES * 32'(cnt);

  always_comb begin
    grp_res = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      grp_res[l*DATA_WIDTH +: DATA_WIDTH] =
        alu(op_q, rs1_q[(grp_base+l)*DATA_WIDTH +: DATA_WIDTH],
                  rs2_q[(grp_base+l)*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      op_err <= 1'b0;
    end else if (!rdy) begin
      op_err <= 1'b0;
    end else begin
      op_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (compute_task.valid) begin
            op_q   <= op_t'(compute_task.op);
            rs1_q  <= compute_task.rs1;
            rs2_q  <= compute_task.rs2;
            rd_q   <= '0;
            cnt    <= '0;
            op_err <= (compute_task.op > OP_MUL);
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          // Abort leaves already-written groups in rd on purpose.
          if (!compute_task.valid) begin
            state <= IDLE;
          end else begin
            rd_q[grp_base*DATA_WIDTH +: GW] <= grp_res;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(GROUPS-1)) begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          if (!compute_task.valid) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign compute_task.rd   = rd_q;
  assign compute_task.done = done_q;
endmodule

// File: doc/gelato_compute_unit.md
Name: gelato_compute_unit

Overview:
Per-warp SIMD ALU that terminates the compute-task protocol: it accepts a task (opcode plus per-thread rs1/rs2 vectors) from the compute scheduler and returns the per-thread result vector with a done handshake. It processes LANES threads per cycle over several cycles. It sits between the compute scheduler and the register writeback path.

Parameters:
THREAD_NUM, 32, threads per warp; vector length.
DATA_WIDTH, 32, bits per thread operand and result.
LANES, 8, threads computed per cycle; must divide THREAD_NUM.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
rdy  in  1  global enable; when low, all state holds.
compute_task.valid  in  1  task request from the scheduler; held high until done is seen.
compute_task.op  in  4  operation code (op_t).
compute_task.rs1  in  THREAD_NUM*DATA_WIDTH  operand A; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
compute_task.rs2  in  THREAD_NUM*DATA_WIDTH  operand B, same lane layout.
compute_task.rd  out  THREAD_NUM*DATA_WIDTH  result vector.
compute_task.done  out  1  result valid; held high until valid drops.
op_err  out  1  one-cycle pulse on capture of an unsupported op.

All compute_task.* signals connect through gelato_compute_task_if.slave.

Behaviour:
- Reset (rst=1 at a posedge): state returns to IDLE; done=0, rd=0, op_err=0; operand latches and group counter are cleared. Reset applies in any state, including mid-compute, and overrides every other input.
- rdy=0: no state, counter, rd, or done change. op_err is forced to 0 that cycle.
- GROUPS = THREAD_NUM/LANES; the counter is clog2(GROUPS) bits.
- IDLE:
  - On valid=1 and rdy=1, latch op, rs1 and rs2. Clear rd and set counter=0.
  - If op is unsupported, pulse op_err and proceed anyway; all result lanes are 0.
  - Go to COMPUTE.
- COMPUTE: each rdy cycle, compute lanes [counter*LANES, counter*LANES+LANES-1] from the latched operands, write them into rd, then counter+1.
  - On the edge that writes the last group: done<=1 and go to DONE.
  - done rises exactly GROUPS enabled cycles after the capture edge. Defaults: capture at edge 0, done visible after edge 4.
  - If valid is 0 during COMPUTE: abort to IDLE; done is never raised and rd is left as partially written.
- DONE: done=1 and rd stable.
  - On valid=0: done<=0 and go to IDLE.
  - A new task can be captured no earlier than the edge after the one that returns to IDLE. There is no back-to-back capture while done=1.
- Input changes to rs1, rs2 or op after capture have no effect; only latched copies are used.
- Ops (per lane, DATA_WIDTH, wrap-around modulo 2^DATA_WIDTH, no overflow flag):
  - ADD a+b; SUB a-b; AND; OR; XOR.
  - SLL a<<b[4:0]; SRL logical; SRA arithmetic.
  - SLT signed a<b gives 1 or 0; SLTU unsigned.
  - MUL: low DATA_WIDTH bits of a*b.
  - Any other code gives 0.
- MUL is combinational over LANES multipliers within one cycle; there is no extra latency for any op.

Test Plan:
- ADD, rs1 lanes = i, rs2 lanes = 0x10 (imm broadcast), valid held -> done rises 4 cycles after capture; rd lane i = 0x10+i for all 32 lanes; done drops the cycle after valid drops.
- SUB with rs1=0, rs2=1 in all lanes -> every lane = 0xFFFFFFFF (wrap). SRA with rs1=0x80000000, rs2=0x24 -> shift 4 -> 0xF8000000. SLT with rs1=0xFFFFFFFF, rs2=0 -> 1, SLTU -> 0.
- rdy held low 3 cycles mid-COMPUTE (after group 1) -> done latency extends to 7 cycles; final rd identical to the no-stall run.
- Change rs1 to all-ones one cycle after capture -> rd reflects the original operands.
- rst asserted on cycle 2 of COMPUTE -> next cycle done=0, rd=0, state IDLE; a fresh task then completes normally in 4 cycles.
- valid dropped in cycle 2 of COMPUTE -> done never asserted. Unsupported op 0xF -> op_err high for exactly one cycle; done after 4 cycles with rd all zero.
